// File: rtl/alu_exec_ctrl_pkg.sv
// Shared LITE-16 definitions: instruction field layout, execute FSM states, imm4 sign extension.
package lite16_pkg;
  localparam int unsigned CODEOP_W = 3;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned OP_LSB   = 13;
  localparam int unsigned RI_BIT   = 12;
  localparam int unsigned RD_LSB   = 8;
  localparam int unsigned RS_LSB   = 4;
  localparam int unsigned RT_LSB   = 0;
  localparam int unsigned IMM_W    = 4;
  localparam int unsigned LITE_W   = 16;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  function automatic logic [LITE_W-1:0] sext_imm4(input logic [IMM_W-1:0] imm);
    return {{(LITE_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction
endpackage

// File: rtl/alu_exec_ctrl_alu.sv
// LITE-16 ALU: combinational r/cmp from codeop, a, b, old rd value and ri.
module alu
  import lite16_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [CODEOP_W-1:0] codeop,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    rd,
  input  logic                ri,
  output logic [WIDTH-1:0]    r,
  output logic                cmp
);
  always_comb begin
    r = '0;
    case (codeop)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[3:0];
      3'd6: r = a >> b[3:0];
      3'd7: r = rd + (ri ? b : a);
      default: r = '0;
    endcase
    cmp = $signed(a) < $signed(b);
  end
endmodule

// File: rtl/alu_exec_ctrl.sv
// Multicycle execute sequencer (IDLE->READ->EXEC->WB) around the LITE-16 ALU.
// Optional ALU_EXEC_PERF_EN adds an op_count completion counter port.
module alu_exec_ctrl
  import lite16_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned RF_AW    = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_instr,
  output logic [RF_AW-1:0]   rf_raddr_a,
  output logic [RF_AW-1:0]   rf_raddr_b,
  output logic [RF_AW-1:0]   rf_raddr_c,
  input  logic [WIDTH-1:0]   rf_rdata_a,
  input  logic [WIDTH-1:0]   rf_rdata_b,
  input  logic [WIDTH-1:0]   rf_rdata_c,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_waddr,
  output logic [WIDTH-1:0]   rf_wdata,
  output logic               cmp_flag,
`ifdef ALU_EXEC_PERF_EN
  output logic [15:0]        op_count,
`endif
  output logic               done
);
  state_t                state, state_nx;
  logic [INSTR_W-1:0]    instr_q;
  logic [WIDTH-1:0]      r_q, alu_r, alu_b;
  logic                  cmp_q, alu_cmp;
  logic [CODEOP_W-1:0]   op;
  logic                  ri;
  logic [IDX_W-1:0]      rd_idx, rs_idx, rt_idx;

  assign op     = instr_q[OP_LSB +: CODEOP_W];
  assign ri     = instr_q[RI_BIT];
  assign rd_idx = instr_q[RD_LSB +: IDX_W];
  assign rs_idx = instr_q[RS_LSB +: IDX_W];
  assign rt_idx = instr_q[RT_LSB +: IDX_W];

  // RF read data is the registered operand set; the ALU sees it directly during EXEC.
  assign alu_b = ri ? WIDTH'(sext_imm4(rt_idx)) : rf_rdata_b;

  alu #(.WIDTH(WIDTH)) u_alu (
    .codeop (op),
    .a      (rf_rdata_a),
    .b      (alu_b),
    .rd     (rf_rdata_c),
    .ri     (ri),
    .r      (alu_r),
    .cmp    (alu_cmp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      instr_q  <= '0;
      r_q      <= '0;
      cmp_q    <= 1'b0;
      cmp_flag <= 1'b0;
`ifdef ALU_EXEC_PERF_EN
      op_count <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) instr_q <= in_instr;
      if (state == EXEC) begin
        r_q   <= alu_r;
        cmp_q <= alu_cmp;
      end
      if (state == WB) begin
        cmp_flag <= cmp_q;
`ifdef ALU_EXEC_PERF_EN
        op_count <= op_count + 16'd1;
`endif
      end
    end
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    rf_raddr_c = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = READ;
      end
      READ, EXEC, WB: begin
        rf_raddr_a = RF_AW'(rs_idx);
        rf_raddr_b = RF_AW'(rt_idx);
        rf_raddr_c = RF_AW'(rd_idx);
        if (state == READ) state_nx = EXEC;
        else if (state == EXEC) state_nx = WB;
        else begin
          done     = 1'b1;
          rf_we    = !((ZERO_REG != 0) && (rd_idx == '0));
          rf_waddr = RF_AW'(rd_idx);
          rf_wdata = r_q;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: bench-side register file, transaction-level model, directed vectors.
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_raddr_c, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_rdata_c, rf_wdata;
  logic        rf_we, cmp_flag, done;
`ifdef ALU_EXEC_PERF_EN
  logic [15:0] op_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.WIDTH(16), .RF_AW(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_raddr_c(rf_raddr_c),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_rdata_c(rf_rdata_c),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cmp_flag(cmp_flag),
`ifdef ALU_EXEC_PERF_EN
    .op_count(op_count),
`endif
    .done(done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int init_val(input int i);
    return (i == 1) ? 7 : (i == 2) ? 6 : (i == 3) ? 5 : 0;
  endfunction

  function automatic logic [15:0] mk(input int op, input int ri, input int rd, input int rs, input int rt);
    logic [15:0] w;
    w = {op[2:0], ri[0], rd[3:0], rs[3:0], rt[3:0]};
    return w;
  endfunction

  // Register file seen by the DUT: sync read, R0 hard-wired to zero.
  logic [15:0] rf_p [16];
  logic        p_init = 1'b0;
  always @(posedge clk) begin
    if (!p_init) begin
      for (int i = 0; i < 16; i++) rf_p[i] <= 16'(init_val(i));
      p_init <= 1'b1;
    end else if (rf_we && rf_waddr != 4'd0) rf_p[rf_waddr] <= rf_wdata;
    rf_rdata_a <= (rf_raddr_a == 4'd0) ? 16'h0 : rf_p[rf_raddr_a];
    rf_rdata_b <= (rf_raddr_b == 4'd0) ? 16'h0 : rf_p[rf_raddr_b];
    rf_rdata_c <= (rf_raddr_c == 4'd0) ? 16'h0 : rf_p[rf_raddr_c];
  end

  // Behavioural ALU in plain integer arithmetic.
  function automatic void alu_model(input int op, input int a, input int b, input int rd, input bit ri,
                                    output int r, output bit c);
    int sa, sb;
    case (op)
      0: r = (a + b) % 65536;
      1: r = (a + 65536 - b) % 65536;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a * (1 << (b % 16))) % 65536;
      6: r = a / (1 << (b % 16));
      default: r = (rd + (ri ? b : a)) % 65536;
    endcase
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    c = sa < sb;
  endfunction

  // Transaction model: accept when idle, WB three cycles later, one instruction in flight.
  int  rf_m [16];
  bit  m_init = 0, started = 0, m_busy = 0, m_cmp = 0, m_c = 0;
  int  m_phase = 0, m_rd = 0, m_rs = 0, m_rt = 0, m_r = 0, m_cnt = 0;
  always @(posedge clk) begin
    int op, imm, b;
    bit ri;
    started = 1;
    if (!m_init) begin
      for (int i = 0; i < 16; i++) rf_m[i] = init_val(i);
      m_init = 1;
    end
    if (rst) begin
      m_busy = 0; m_phase = 0; m_cmp = 0; m_cnt = 0;
    end else if (m_busy) begin
      if (m_phase == 3) begin
        if (m_rd != 0) rf_m[m_rd] = m_r;
        m_cmp = m_c;
        m_cnt = (m_cnt + 1) % 65536;
        m_busy = 0;
      end else m_phase++;
    end else if (in_valid) begin
      op   = int'(in_instr[15:13]);
      ri   = in_instr[12];
      m_rd = int'(in_instr[11:8]);
      m_rs = int'(in_instr[7:4]);
      m_rt = int'(in_instr[3:0]);
      imm  = m_rt;
      b    = ri ? ((imm >= 8) ? imm + 65520 : imm) : rf_m[m_rt];
      alu_model(op, rf_m[m_rs], b, rf_m[m_rd], ri, m_r, m_c);
      m_busy = 1; m_phase = 1;
    end
  end

  always @(negedge clk) begin
    bit wb;
    if (started) begin
      wb = m_busy && m_phase == 3;
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("done", 32'(done), 32'(wb));
      check("rf_we", 32'(rf_we), 32'(wb && m_rd != 0));
      check("rf_waddr", 32'(rf_waddr), wb ? m_rd : 0);
      check("rf_wdata", 32'(rf_wdata), wb ? m_r : 0);
      check("cmp_flag", 32'(cmp_flag), 32'(m_cmp));
      check("raddr_a", 32'(rf_raddr_a), m_busy ? m_rs : 0);
      check("raddr_b", 32'(rf_raddr_b), m_busy ? m_rt : 0);
      check("raddr_c", 32'(rf_raddr_c), m_busy ? m_rd : 0);
`ifdef ALU_EXEC_PERF_EN
      check("op_count", 32'(op_count), m_cnt);
`endif
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_one(input string nm, input logic [15:0] ins, input logic [15:0] exp_w,
                         input bit exp_we, input bit exp_c);
    wait_ready();
    in_valid = 1'b1; in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0; in_instr = 16'($urandom);
    check({nm, "_busy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_we"}, 32'(rf_we), 32'(exp_we));
    check({nm, "_wdata"}, 32'(rf_wdata), 32'(exp_w));
    @(negedge clk);
    check({nm, "_cmp"}, 32'(cmp_flag), 32'(exp_c));
  endtask

  initial begin
    int exp_reg [8] = '{13, 1, 6, 7, 1, 448, 0, 7};
    int exp_imm [8] = '{13, 1, 6, 7, 1, 448, 0, 6};
    int dones;
    logic [15:0] seen [$];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 32'(in_ready), 32'd1);

    run_one("reg_add", mk(0, 0, 3, 1, 2), 16'd13, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) run_one($sformatf("reg_op%0d", i), mk(i, 0, 8, 1, 2), 16'(exp_reg[i]), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) run_one($sformatf("imm_op%0d", i), mk(i, 1, 8, 1, 6), 16'(exp_imm[i]), 1'b1, 1'b0);

    run_one("sext_add", mk(0, 1, 4, 1, 15), 16'd6, 1'b1, 1'b0);
    run_one("sext_sub", mk(1, 1, 4, 1, 15), 16'd8, 1'b1, 1'b0);
    run_one("sext_min", mk(0, 1, 4, 1, 8), 16'hFFFF, 1'b1, 1'b0);

    run_one("zero_reg", mk(1, 0, 0, 2, 1), 16'hFFFF, 1'b0, 1'b1);
    run_one("r0_read", mk(0, 0, 5, 0, 1), 16'd7, 1'b1, 1'b1);

    wait_ready();
    in_valid = 1'b1; in_instr = mk(0, 0, 6, 1, 2);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_exec_done", 32'(done), 32'd0);
    check("rst_exec_we", 32'(rf_we), 32'd0);
    check("rst_exec_cmp", 32'(cmp_flag), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    run_one("post_rst", mk(0, 0, 7, 6, 1), 16'd7, 1'b1, 1'b1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    in_valid = 1'b1; in_instr = mk(0, 0, 9, 1, 2);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) in_instr = mk(3, 0, 10, 1, 2);
      if (c == 4) in_instr = mk(0, 0, 11, 9, 10);
      if (c == 8) in_valid = 1'b0;
      if (done) begin
        dones++;
        seen.push_back(rf_wdata);
      end
    end
    check("b2b_dones", 32'(dones), 32'd3);
    check("b2b_w0", (seen.size() > 0) ? 32'(seen[0]) : 32'hDEAD, 32'd13);
    check("b2b_w1", (seen.size() > 1) ? 32'(seen[1]) : 32'hDEAD, 32'd7);
    check("b2b_w2", (seen.size() > 2) ? 32'(seen[2]) : 32'hDEAD, 32'd20);
`ifdef ALU_EXEC_PERF_EN
    check("op_count_3", 32'(op_count), 32'd3);
    force dut.op_count = 16'hFFFF;
    m_cnt = 65535;
    @(negedge clk);
    release dut.op_count;
    run_one("wrap", mk(0, 0, 12, 1, 2), 16'd13, 1'b1, 1'b0);
    check("op_count_wrap", 32'(op_count), 32'd0);
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
